// File: rtl/decoder_select_sequencer.sv
// Select sequencer for a 2-to-4 decoder: paces {a,b} through up, down or ping-pong scans.
// Step and wrap strobes are registered and line up with each new select value.
module decoder_select_sequencer #(
   parameter int TICK_DIV = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic [1:0] mode,
   input  logic       load,
   input  logic [1:0] load_val,
   output logic       a,
   output logic       b,
   output logic       dir,
   output logic       step,
   output logic       wrap
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PC_LAST = PW'(TICK_DIV - 1);

   localparam logic [1:0] MODE_UP     = 2'b00;
   localparam logic [1:0] MODE_DOWN   = 2'b01;
   localparam logic [1:0] MODE_PING   = 2'b10;
   localparam logic [1:0] MODE_MANUAL = 2'b11;

   logic [1:0]    sel;
   logic [PW-1:0] pc;
   logic [1:0]    nxt_sel;
   logic          nxt_dir;
   logic          nxt_wrap;

   assign a = sel[1];
   assign b = sel[0];

   // Select value, direction and wrap flag that a step would produce this cycle.
   always_comb begin
      nxt_sel  = sel;
      nxt_dir  = dir;
      nxt_wrap = 1'b0;
      case (mode)
         MODE_UP: begin
            nxt_sel  = sel + 2'd1;
            nxt_wrap = (sel == 2'd3);
         end
         MODE_DOWN: begin
            nxt_sel  = sel - 2'd1;
            nxt_wrap = (sel == 2'd0);
         end
         MODE_PING: begin
            if (!dir) begin
               if (sel == 2'd3) begin
                  nxt_sel  = 2'd2;
                  nxt_dir  = 1'b1;
                  nxt_wrap = 1'b1;
               end else begin
                  nxt_sel = sel + 2'd1;
               end
            end else begin
               if (sel == 2'd0) begin
                  nxt_sel  = 2'd1;
                  nxt_dir  = 1'b0;
                  nxt_wrap = 1'b1;
               end else begin
                  nxt_sel = sel - 2'd1;
               end
            end
         end
         default: begin
            nxt_sel  = sel;
            nxt_dir  = dir;
            nxt_wrap = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sel  <= 2'd0;
         pc   <= '0;
         dir  <= 1'b0;
         step <= 1'b0;
         wrap <= 1'b0;
      end else if (load) begin
         sel  <= load_val;
         pc   <= '0;
         dir  <= 1'b0;
         step <= 1'b0;
         wrap <= 1'b0;
      end else if (en && (mode != MODE_MANUAL)) begin
         if (pc == PC_LAST) begin
            pc   <= '0;
            sel  <= nxt_sel;
            dir  <= nxt_dir;
            step <= 1'b1;
            wrap <= nxt_wrap;
         end else begin
            pc   <= pc + PW'(1);
            step <= 1'b0;
            wrap <= 1'b0;
         end
      end else begin
         step <= 1'b0;
         wrap <= 1'b0;
      end
   end

endmodule

// File: tb/tb_decoder_select_sequencer.sv
// Directed bench for decoder_select_sequencer: one TICK_DIV=4 instance and one TICK_DIV=1 instance.
module tb_decoder_select_sequencer;

   localparam int TD = 4;

   logic       clk;
   logic       reset;
   logic       en, load;
   logic [1:0] mode, load_val;
   logic       a, b, dir, step, wrap;

   logic       en1;
   logic [1:0] mode1;
   logic       a1, b1, dir1, step1, wrap1;

   int n_cmp;
   int n_err;

   decoder_select_sequencer #(.TICK_DIV(TD)) dut (
      .clk(clk), .reset(reset), .en(en), .mode(mode), .load(load), .load_val(load_val),
      .a(a), .b(b), .dir(dir), .step(step), .wrap(wrap)
   );

   decoder_select_sequencer #(.TICK_DIV(1)) dut1 (
      .clk(clk), .reset(reset), .en(en1), .mode(mode1), .load(1'b0), .load_val(2'b00),
      .a(a1), .b(b1), .dir(dir1), .step(step1), .wrap(wrap1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #3;
      reset = 1'b0;
   endtask

   // TD-1 quiet edges, then one edge carrying the step.
   task automatic step_expect(input string tag, input logic [1:0] es, input logic ew, input logic ed);
      for (int i = 0; i < TD - 1; i++) begin
         tick();
         check_eq({tag, "_quiet"}, {7'd0, step}, 8'd0);
      end
      tick();
      check_eq({tag, "_sel"}, {6'd0, a, b}, {6'd0, es});
      check_eq({tag, "_step"}, {7'd0, step}, 8'd1);
      check_eq({tag, "_wrap"}, {7'd0, wrap}, {7'd0, ew});
      check_eq({tag, "_dir"}, {7'd0, dir}, {7'd0, ed});
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      reset = 1'b1;
      en = 1'b1; mode = 2'b00; load = 1'b0; load_val = 2'b00;
      en1 = 1'b0; mode1 = 2'b00;

      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_sel", {6'd0, a, b}, 8'd0);
      check_eq("rst_dir", {7'd0, dir}, 8'd0);
      check_eq("rst_step", {7'd0, step}, 8'd0);
      check_eq("rst_wrap", {7'd0, wrap}, 8'd0);
      reset = 1'b0;

      // Up scan: a step on every fourth edge, wrap on edge 16.
      for (int k = 1; k <= 26; k++) begin
         tick();
         check_eq("up_sel", {6'd0, a, b}, 8'((k / 4) % 4));
         check_eq("up_step", {7'd0, step}, (k % 4 == 0) ? 8'd1 : 8'd0);
         check_eq("up_wrap", {7'd0, wrap}, (k % 16 == 0) ? 8'd1 : 8'd0);
      end

      // Asynchronous reset with pc=2, sel=2, away from any edge.
      #2;
      reset = 1'b1;
      #1;
      check_eq("async_sel", {6'd0, a, b}, 8'd0);
      check_eq("async_step", {7'd0, step}, 8'd0);
      @(negedge clk);
      reset = 1'b0;
      step_expect("after_rst", 2'd1, 1'b0, 1'b0);

      // Down scan from 0.
      load = 1'b1; load_val = 2'd0; mode = 2'b01;
      tick();
      load = 1'b0;
      check_eq("dn_load_sel", {6'd0, a, b}, 8'd0);
      check_eq("dn_load_step", {7'd0, step}, 8'd0);
      step_expect("dn1", 2'd3, 1'b1, 1'b0);
      step_expect("dn2", 2'd2, 1'b0, 1'b0);

      // Ping-pong from reset.
      mode = 2'b10;
      do_reset();
      step_expect("pp1", 2'd1, 1'b0, 1'b0);
      step_expect("pp2", 2'd2, 1'b0, 1'b0);
      step_expect("pp3", 2'd3, 1'b0, 1'b0);
      step_expect("pp4", 2'd2, 1'b1, 1'b1);
      step_expect("pp5", 2'd1, 1'b0, 1'b1);
      step_expect("pp6", 2'd0, 1'b0, 1'b1);
      step_expect("pp7", 2'd1, 1'b1, 1'b0);

      // Enable gating at pc=2 for 7 cycles.
      mode = 2'b00;
      tick();
      tick();
      check_eq("en_pre_step", {7'd0, step}, 8'd0);
      en = 1'b0;
      for (int i = 0; i < 7; i++) begin
         tick();
         check_eq("en_off_step", {7'd0, step}, 8'd0);
         check_eq("en_off_sel", {6'd0, a, b}, 8'd1);
      end
      en = 1'b1;
      tick();
      check_eq("en_re1_step", {7'd0, step}, 8'd0);
      tick();
      check_eq("en_re2_step", {7'd0, step}, 8'd1);
      check_eq("en_re2_sel", {6'd0, a, b}, 8'd2);

      // Load on the edge that would otherwise step.
      repeat (3) tick();
      load = 1'b1; load_val = 2'b10;
      tick();
      load = 1'b0;
      check_eq("ld_sel", {6'd0, a, b}, 8'd2);
      check_eq("ld_step", {7'd0, step}, 8'd0);
      check_eq("ld_wrap", {7'd0, wrap}, 8'd0);
      step_expect("ld_next", 2'd3, 1'b0, 1'b0);

      // Manual mode: select moves only on load.
      mode = 2'b11;
      for (int i = 0; i < 20; i++) begin
         tick();
         check_eq("man_sel", {6'd0, a, b}, 8'd3);
         check_eq("man_step", {7'd0, step}, 8'd0);
      end
      load = 1'b1; load_val = 2'd1;
      tick();
      load = 1'b0;
      check_eq("man_load_sel", {6'd0, a, b}, 8'd1);
      repeat (8) tick();
      check_eq("man_hold_sel", {6'd0, a, b}, 8'd1);

      // Ping-pong entered at sel=3 with dir=0 turns around on the first step.
      load = 1'b1; load_val = 2'd3;
      tick();
      load = 1'b0;
      mode = 2'b10;
      step_expect("pp_edge", 2'd2, 1'b1, 1'b1);

      // TICK_DIV=1 instance: step every edge, wrap every fourth.
      en = 1'b0;
      do_reset();
      en1 = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         tick();
         check_eq("td1_sel", {6'd0, a1, b1}, 8'(k % 4));
         check_eq("td1_step", {7'd0, step1}, 8'd1);
         check_eq("td1_wrap", {7'd0, wrap1}, (k % 4 == 0) ? 8'd1 : 8'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
